// File: rtl/ddr2dbuf_tile.sv
// ddr2dbuf_tile: streams one input tile from DDR into the banked PE data buffer (CONV scatter / FC interleave).
// Define DDR2DBUF_TILE_PERF_EN to add the stall_cnt performance counter output.
module ddr2dbuf_tile #(
    parameter int DATA_W    = 16,
    parameter int BATCH     = 32,
    parameter int BANK_ROW  = 2,
    parameter int BANK_PIX  = 2,
    parameter int BUF_DEPTH = 256,
    parameter int CNT_W     = 4,
    parameter int FC_W      = 12,
    localparam int ADDR_W   = $clog2(BUF_DEPTH),
    localparam int DDR_W    = DATA_W * BATCH,
    localparam int BANK_NUM = BANK_ROW * BANK_PIX
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    output logic                               done,
`ifdef DDR2DBUF_TILE_PERF_EN
    output logic [31:0]                        stall_cnt,
`endif
    input  logic [2:0]                         mode,
    input  logic [CNT_W-1:0]                   ch_num,
    input  logic [CNT_W-1:0]                   row_num,
    input  logic [CNT_W-1:0]                   pix_num,
    input  logic [ADDR_W-1:0]                  ch_stride,
    input  logic [ADDR_W-1:0]                  base_addr,
    input  logic [FC_W-1:0]                    fc_len,
    input  logic [DDR_W-1:0]                   ddr_data,
    input  logic                               ddr_valid,
    output logic                               ddr_ready,
    output logic [ADDR_W-1:0]                  dbuf_wr_addr,
    output logic [BANK_NUM-1:0][DDR_W-1:0]     dbuf_wr_data,
    output logic [BANK_NUM-1:0]                dbuf_wr_en
);
    localparam int BI_W = $clog2(BANK_NUM) + 1;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    state_t state;
    logic fc_r, s1_v, acc, ch_last, pix_last, row_last, last, unused_mode;
    logic [CNT_W-1:0] ch_num_r, row_num_r, pix_num_r, ch_cnt, pix_cnt, row_cnt;
    logic [ADDR_W-1:0] stride_r, base_r, pix_q, ch_off, row_off, nxt_addr, s1_addr;
    logic [FC_W-1:0] fc_len_r, fc_cnt;
    logic [DDR_W-1:0] s1_data, out_data;
    logic [BANK_NUM-1:0] s1_en, nxt_en;
    logic [BI_W-1:0] bi;
    assign acc = ddr_ready & ddr_valid;
    assign ch_last = ch_cnt == ch_num_r;
    assign pix_last = pix_cnt == pix_num_r;
    assign row_last = row_cnt == row_num_r;
    assign last = fc_r ? fc_cnt == fc_len_r : ch_last & pix_last & row_last;
    assign bi = fc_r ? BI_W'(fc_cnt % BANK_NUM)
                     : BI_W'((row_cnt % BANK_ROW) * BANK_PIX + pix_cnt % BANK_PIX);
    assign nxt_en = BANK_NUM'(1) << bi;
    // ch_off and row_off are running accumulators standing in for ch*stride and (row/BANK_ROW)*pix_q
    assign nxt_addr = fc_r ? base_r + ADDR_W'(fc_cnt / BANK_NUM)
                           : base_r + ch_off + row_off + ADDR_W'(pix_cnt / BANK_PIX);
    assign dbuf_wr_data = {BANK_NUM{out_data}};
    assign unused_mode = ^mode[2:1];
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            done <= 1'b1;
            ddr_ready <= 1'b0;
            fc_r <= 1'b0;
            ch_num_r <= '0;
            row_num_r <= '0;
            pix_num_r <= '0;
            stride_r <= '0;
            base_r <= '0;
            fc_len_r <= '0;
            pix_q <= '0;
            ch_cnt <= '0;
            pix_cnt <= '0;
            row_cnt <= '0;
            fc_cnt <= '0;
            ch_off <= '0;
            row_off <= '0;
            s1_v <= 1'b0;
            s1_en <= '0;
            s1_addr <= '0;
            s1_data <= '0;
            dbuf_wr_en <= '0;
            dbuf_wr_addr <= '0;
            out_data <= '0;
`ifdef DDR2DBUF_TILE_PERF_EN
            stall_cnt <= '0;
`endif
        end else begin
            s1_v <= acc;
            if (acc) begin
                s1_en <= nxt_en;
                s1_addr <= nxt_addr;
                s1_data <= ddr_data;
            end
            dbuf_wr_en <= s1_v ? s1_en : '0;
            dbuf_wr_addr <= s1_addr;
            out_data <= s1_data;
`ifdef DDR2DBUF_TILE_PERF_EN
            if (state == RUN && ddr_ready && !ddr_valid && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
`endif
            case (state)
                IDLE: if (start) begin
                    state <= RUN;
                    done <= 1'b0;
                    ddr_ready <= 1'b1;
                    fc_r <= mode[0];
                    ch_num_r <= ch_num;
                    row_num_r <= row_num;
                    pix_num_r <= pix_num;
                    stride_r <= ch_stride;
                    base_r <= base_addr;
                    fc_len_r <= fc_len;
                    pix_q <= ADDR_W'(pix_num / BANK_PIX + 1);
                    ch_cnt <= '0;
                    pix_cnt <= '0;
                    row_cnt <= '0;
                    fc_cnt <= '0;
                    ch_off <= '0;
                    row_off <= '0;
`ifdef DDR2DBUF_TILE_PERF_EN
                    stall_cnt <= '0;
`endif
                end
                RUN: if (acc) begin
                    if (last) begin
                        state <= DRAIN;
                        ddr_ready <= 1'b0;
                    end
                    fc_cnt <= fc_cnt + 1'b1;
                    if (!ch_last) begin
                        ch_cnt <= ch_cnt + 1'b1;
                        ch_off <= ch_off + stride_r;
                    end else begin
                        ch_cnt <= '0;
                        ch_off <= '0;
                        pix_cnt <= pix_last ? '0 : pix_cnt + 1'b1;
                        if (pix_last && !row_last) begin
                            row_cnt <= row_cnt + 1'b1;
                            if ((row_cnt % BANK_ROW) == BANK_ROW - 1)
                                row_off <= row_off + pix_q;
                        end
                    end
                end
                DRAIN: if (!s1_v) begin
                    state <= IDLE;
                    done <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ddr2dbuf_tile.sv
// tb_ddr2dbuf_tile: directed self-checking bench for ddr2dbuf_tile (CONV, FC, stalls, reset, ignored start, wrap).
module tb_ddr2dbuf_tile;
    localparam int BATCH = 32;
    localparam int NB = 4;
    localparam int DDR_W = 512;
    logic clk = 1'b0;
    logic rst, start, done, ddr_valid, ddr_ready;
    logic [2:0] mode;
    logic [3:0] ch_num, row_num, pix_num;
    logic [7:0] ch_stride, base_addr, dbuf_wr_addr;
    logic [11:0] fc_len;
    logic [DDR_W-1:0] ddr_data;
    logic [NB-1:0][DDR_W-1:0] dbuf_wr_data;
    logic [NB-1:0] dbuf_wr_en;
`ifdef DDR2DBUF_TILE_PERF_EN
    logic [31:0] stall_cnt;
`endif
    ddr2dbuf_tile dut (
        .clk(clk), .rst(rst), .start(start), .done(done),
`ifdef DDR2DBUF_TILE_PERF_EN
        .stall_cnt(stall_cnt),
`endif
        .mode(mode), .ch_num(ch_num), .row_num(row_num), .pix_num(pix_num),
        .ch_stride(ch_stride), .base_addr(base_addr), .fc_len(fc_len),
        .ddr_data(ddr_data), .ddr_valid(ddr_valid), .ddr_ready(ddr_ready),
        .dbuf_wr_addr(dbuf_wr_addr), .dbuf_wr_data(dbuf_wr_data), .dbuf_wr_en(dbuf_wr_en)
    );
    always #5 clk = ~clk;
    int n_cmp = 0, n_bad = 0;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    typedef struct {
        logic [NB-1:0] en;
        logic [7:0] addr;
        logic [15:0] d0;
        logic [15:0] d3;
    } wr_t;
    wr_t q[$];
    int cyc = 0, last_wr = 0, done_rise = 0;
    logic done_d = 1'b1;
    always @(negedge clk) begin
        cyc++;
        if (|dbuf_wr_en) begin
            q.push_back('{dbuf_wr_en, dbuf_wr_addr, dbuf_wr_data[0][15:0], dbuf_wr_data[NB-1][DDR_W-1 -: 16]});
            last_wr = cyc;
        end
        if (done === 1'b1 && done_d !== 1'b1) done_rise = cyc;
        done_d = done;
    end
    task automatic run(input logic fc, input logic [3:0] ch, input logic [3:0] row, input logic [3:0] pix,
                       input logic [7:0] stride, input logic [7:0] base, input logic [11:0] fl,
                       input int n, input bit toggle, input bit glitch, input int rst_after);
        int nb = 0;
        int i = 0;
        bit acc;
        @(posedge clk); #1;
        mode = {2'b00, fc}; ch_num = ch; row_num = row; pix_num = pix;
        ch_stride = stride; base_addr = base; fc_len = fl; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy", done, 0);
        while (nb < n && i < 200) begin
            ddr_valid = toggle ? (i % 2 == 0) : 1'b1;
            ddr_data = {BATCH{16'hA000 + 16'(nb)}};
            if (glitch && i == 3) begin
                start = 1'b1; mode = 3'b001; ch_num = 4'd0; base_addr = 8'h55; fc_len = 12'd9;
            end else start = 1'b0;
            acc = ddr_valid && ddr_ready;
            @(posedge clk); #1;
            if (acc) nb++;
            i++;
            if (rst_after != 0 && nb == rst_after) break;
        end
        ddr_valid = 1'b0;
        start = 1'b0;
        if (rst_after == 0) begin
            check("beats", nb, n);
            check("ready_drop", ddr_ready, 0);
            for (int j = 0; j < 50 && done !== 1'b1; j++) begin
                @(posedge clk); #1;
            end
            @(negedge clk); #1;
            check("done", done, 1);
            check("done_lag", done_rise - last_wr, 1);
        end
    endtask
    task automatic check_seq(input string t, input int n, input int eb[8], input int ea[8]);
        check($sformatf("%s_count", t), q.size(), n);
        for (int i = 0; i < n && i < q.size(); i++) begin
            check($sformatf("%s_en%0d", t, i), q[i].en, 64'(1) << eb[i]);
            check($sformatf("%s_addr%0d", t, i), q[i].addr, ea[i]);
            check($sformatf("%s_d0_%0d", t, i), q[i].d0, 16'hA000 + 16'(i));
            check($sformatf("%s_d3_%0d", t, i), q[i].d3, 16'hA000 + 16'(i));
        end
    endtask
    int c1b[8] = '{0, 0, 1, 1, 2, 2, 3, 3};
    int c1a[8] = '{8, 12, 8, 12, 8, 12, 8, 12};
    int fcb[8] = '{0, 1, 2, 3, 0, 1, 0, 0};
    int fca[8] = '{16, 16, 16, 16, 17, 17, 0, 0};
    int wrb[8] = '{0, 0, 0, 0, 0, 0, 0, 0};
    int wra[8] = '{254, 2, 0, 0, 0, 0, 0, 0};
    initial begin
        rst = 1'b1; start = 1'b0; ddr_valid = 1'b0; ddr_data = '0; mode = '0;
        ch_num = '0; row_num = '0; pix_num = '0; ch_stride = '0; base_addr = '0; fc_len = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_done", done, 1);
        check("rst_ready", ddr_ready, 0);
        check("rst_en", dbuf_wr_en, 0);
        check("rst_addr", dbuf_wr_addr, 0);
        check("rst_data", dbuf_wr_data[0][63:0], 0);
        // rst wins over a simultaneous start
        rst = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        check("rst_start_done", done, 1);
        check("rst_start_ready", ddr_ready, 0);
        q.delete();
        run(1'b0, 4'd1, 4'd1, 4'd1, 8'd4, 8'd8, 12'd0, 8, 1'b0, 1'b0, 0);
        check_seq("conv", 8, c1b, c1a);
`ifdef DDR2DBUF_TILE_PERF_EN
        check("stall_none", stall_cnt, 0);
`endif
        q.delete();
        run(1'b1, 4'd0, 4'd0, 4'd0, 8'd0, 8'd16, 12'd5, 6, 1'b0, 1'b0, 0);
        check_seq("fc", 6, fcb, fca);
        q.delete();
        run(1'b0, 4'd1, 4'd1, 4'd1, 8'd4, 8'd8, 12'd0, 8, 1'b1, 1'b0, 0);
        check_seq("stall", 8, c1b, c1a);
`ifdef DDR2DBUF_TILE_PERF_EN
        check("stall_cnt", stall_cnt, 7);
`endif
        run(1'b0, 4'd1, 4'd1, 4'd1, 8'd4, 8'd8, 12'd0, 8, 1'b0, 1'b0, 3);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_done", done, 1);
        check("midrst_en", dbuf_wr_en, 0);
        check("midrst_ready", ddr_ready, 0);
        q.delete();
        repeat (4) @(posedge clk);
        #1;
        run(1'b0, 4'd1, 4'd1, 4'd1, 8'd4, 8'd8, 12'd0, 8, 1'b0, 1'b0, 0);
        check_seq("rerun", 8, c1b, c1a);
        q.delete();
        run(1'b0, 4'd1, 4'd1, 4'd1, 8'd4, 8'd8, 12'd0, 8, 1'b0, 1'b1, 0);
        check_seq("glitch", 8, c1b, c1a);
        q.delete();
        run(1'b0, 4'd1, 4'd0, 4'd0, 8'd4, 8'd254, 12'd0, 2, 1'b0, 1'b0, 0);
        check_seq("wrap", 2, wrb, wra);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
